countdown_timer: RTL

Loadable down-counting timer, the count-down counterpart to the team's up-counters.
- Software or an FSM loads a period and starts it.
- The timer decrements on qualified ticks and emits a one-cycle TRIG_OUT on expiry.
- Sits beside the up-counter chain in the microprocessor peripheral set, for delays and timeouts.

---
 rtl/countdown_timer_pkg.sv | 14 +
 rtl/countdown_timer.sv | 103 ++++++++++
 2 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the loadable down-counting timer.
// State encoding is visible on the STATE port, so values are fixed.
package countdown_timer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-cycle expiry pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic (auto-reload) operation.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int COUNTER_WIDTH = DEFAULT_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     LOAD,
    input  logic [COUNTER_WIDTH-1:0] LOAD_VALUE,
    input  logic                     START,
    input  logic                     STOP,
    input  logic                     TICK_IN,
    output logic [COUNTER_WIDTH-1:0] COUNT,
    output logic                     TRIG_OUT,
    output logic                     BUSY,
    output logic [1:0]               STATE
);

    localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

    state_t                   state;
    logic [COUNTER_WIDTH-1:0] count;
    logic [COUNTER_WIDTH-1:0] reload;
    logic                     trig;
    logic                     is_zero;
    logic                     is_one;
    logic                     reload_zero;
    logic                     expire_evt;

    assign is_zero     = (count == '0);
    assign is_one      = (count == ONE);
    assign reload_zero = (reload == '0);

    // Same decisions as the FSM below, reduced to "an expiry happens now".
    always_comb begin
        expire_evt = 1'b0;
        if (!LOAD) begin
            unique case (state)
                ST_IDLE, ST_PAUSED: expire_evt = START && is_zero;
                ST_RUNNING:         expire_evt = !STOP && TICK_IN && is_one;
                ST_EXPIRED:         expire_evt = START && reload_zero;
                default:            expire_evt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= ST_IDLE;
            count  <= '0;
            reload <= '0;
        end else if (LOAD) begin
            state  <= ST_IDLE;
            count  <= LOAD_VALUE;
            reload <= LOAD_VALUE;
        end else begin
            unique case (state)
                ST_IDLE, ST_PAUSED: begin
                    if (START)
                        state <= is_zero ? ST_EXPIRED : ST_RUNNING;
                end
                ST_RUNNING: begin
                    if (STOP) begin
                        state <= ST_PAUSED;
                    end else if (TICK_IN) begin
                        if (is_one) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            count <= reload;
`else
                            count <= '0;
                            state <= ST_EXPIRED;
`endif
                        end else if (!is_zero) begin
                            count <= count - ONE;
                        end
                    end
                end
                ST_EXPIRED: begin
                    if (START) begin
                        count <= reload;
                        state <= reload_zero ? ST_EXPIRED : ST_RUNNING;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET)
            trig <= 1'b0;
        else
            trig <= expire_evt;
    end

    assign COUNT    = count;
    assign TRIG_OUT = trig;
    assign BUSY     = (state == ST_RUNNING);
    assign STATE    = state;

endmodule
